// File: rtl/sensor_conditioner_if.sv
// rtl/sensor_conditioner_if.sv - signal bundle between sensor probes and the conditioner
//
// Purpose: groups the raw probe/switch inputs, the error-clear request and the
// conditioned outputs of sensor_conditioner into one interface.
// Signals:
//   hh_raw, mm_raw, ll_raw  raw tank level probes (high, medium, low)
//   ua_raw, us_raw, t_raw   raw air-humidity, soil-humidity, temperature switches
//   err_clr                 request to clear the sticky level_err
//   hh, mm, ll, ua, us, t   debounced sensor values
//   level_code              0 empty, 1 low, 2 medium, 3 full
//   changed                 one-cycle pulse per debounced update edge
//   level_err               sticky probe-plausibility error
// Modports: master drives the raw side, slave is the conditioner.

interface sensor_conditioner_if;
  logic       hh_raw;
  logic       mm_raw;
  logic       ll_raw;
  logic       ua_raw;
  logic       us_raw;
  logic       t_raw;
  logic       err_clr;
  logic       hh;
  logic       mm;
  logic       ll;
  logic       ua;
  logic       us;
  logic       t;
  logic [1:0] level_code;
  logic       changed;
  logic       level_err;

  modport master (
    output hh_raw, mm_raw, ll_raw, ua_raw, us_raw, t_raw, err_clr,
    input  hh, mm, ll, ua, us, t, level_code, changed, level_err
  );

  modport slave (
    input  hh_raw, mm_raw, ll_raw, ua_raw, us_raw, t_raw, err_clr,
    output hh, mm, ll, ua, us, t, level_code, changed, level_err
  );
endinterface

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - synchronizes, debounces and classifies tank/irrigation sensors
//
// Purpose: each of six raw sensor bits passes a 2-flop synchronizer and a
// per-channel debounce counter. The three tank probes are mapped to a level
// code; implausible probe combinations hold the last valid code.
// Optional feature macro: SENSOR_PLAUSIBILITY_EN enables the implausibility
// counter and the sticky level_err flag (cleared by err_clr on a valid pattern).
// Without it level_err is tied 0 and err_clr is ignored.
// Parameters:
//   DEBOUNCE_CYCLES  consecutive mismatching cycles to accept a new level (2..255)
//   ERR_HOLD         consecutive implausible cycles to raise level_err (1..15)
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-low reset
//   bus    sensor_conditioner_if.slave (raw inputs, err_clr, conditioned outputs)

module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ERR_HOLD        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sensor_conditioner_if.slave   bus
);

  localparam int         NCH      = 6;
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Channel order: {t, us, ua, hh, mm, ll}; bits [2:0] are the level probes.
  logic [NCH-1:0]      w_raw;
  logic [NCH-1:0]      r_sync1;
  logic [NCH-1:0]      r_sync2;
  logic [NCH-1:0]      r_deb;
  logic [NCH-1:0][7:0] r_cnt;
  logic [NCH-1:0]      w_load;
  logic                r_changed;
  logic [1:0]          r_level_code;
  logic [2:0]          w_pat;
  logic                w_valid;
  logic [1:0]          w_code;

  assign w_raw = {bus.t_raw, bus.us_raw, bus.ua_raw, bus.hh_raw, bus.mm_raw, bus.ll_raw};

  // A channel loads on the edge its counter has already seen DEBOUNCE_CYCLES-1
  // mismatching cycles and the mismatch is still present.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < NCH; i++) begin
      w_load[i] = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_deb     <= '0;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NCH; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= 8'd0;
        end else if (w_load[i]) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= 8'd0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
      // Follows the load edge exactly, so back-to-back updates give back-to-back pulses.
      r_changed <= |w_load;
    end
  end

  assign w_pat = r_deb[2:0];

  always_comb begin
    w_valid = 1'b1;
    w_code  = 2'd0;
    case (w_pat)
      3'b000:  w_code = 2'd0;
      3'b001:  w_code = 2'd1;
      3'b011:  w_code = 2'd2;
      3'b111:  w_code = 2'd3;
      default: w_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_level_code <= 2'd0;
    end else if (w_valid) begin
      r_level_code <= w_code;
    end
  end

`ifdef SENSOR_PLAUSIBILITY_EN
  localparam logic [3:0] HOLD = 4'(ERR_HOLD);

  logic [3:0] r_imp_cnt;
  logic       r_level_err;

  // The flag sets on the edge the counter steps onto HOLD; while the pattern
  // stays invalid err_clr cannot clear it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_imp_cnt   <= 4'd0;
      r_level_err <= 1'b0;
    end else if (w_valid) begin
      r_imp_cnt <= 4'd0;
      if (bus.err_clr) begin
        r_level_err <= 1'b0;
      end
    end else begin
      if (r_imp_cnt != HOLD) begin
        r_imp_cnt <= r_imp_cnt + 4'd1;
      end
      if (r_imp_cnt >= HOLD - 4'd1) begin
        r_level_err <= 1'b1;
      end
    end
  end

  assign bus.level_err = r_level_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr;
  assign bus.level_err    = 1'b0;
`endif

  assign bus.ll         = r_deb[0];
  assign bus.mm         = r_deb[1];
  assign bus.hh         = r_deb[2];
  assign bus.ua         = r_deb[3];
  assign bus.us         = r_deb[4];
  assign bus.t          = r_deb[5];
  assign bus.level_code = r_level_code;
  assign bus.changed    = r_changed;

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - directed vector bench for sensor_conditioner
//
// Purpose: applies a table of raw input patterns with hand-computed debounced
// outputs and level codes, tracking every edge of each debounce window, plus
// hand-written sequences for glitch rejection, plausibility error and reset
// during a pending count.
// Ports: none (top-level bench).

module tb_sensor_conditioner;

  localparam int D  = 16;
  localparam int EH = 4;
`ifdef SENSOR_PLAUSIBILITY_EN
  localparam logic PL = 1'b1;
`else
  localparam logic PL = 1'b0;
`endif

  typedef struct {
    logic [5:0] raw;   // {t, us, ua, hh, mm, ll}
    logic [5:0] deb;
    logic [1:0] code;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sensor_conditioner_if bus ();

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .ERR_HOLD       (EH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [5:0] prev_deb;
  logic [1:0] prev_code;
  vec_t       vecs [7];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [5:0] r);
    bus.t_raw  = r[5];
    bus.us_raw = r[4];
    bus.ua_raw = r[3];
    bus.hh_raw = r[2];
    bus.mm_raw = r[1];
    bus.ll_raw = r[0];
  endtask

  function automatic logic [7:0] deb_out();
    return {2'b00, bus.t, bus.us, bus.ua, bus.hh, bus.mm, bus.ll};
  endfunction

  // Drives v.raw, then checks every edge 1..D+3: old values through edge D+1,
  // debounced update and changed pulse at D+2, level code at D+3.
  task automatic apply_vec(input vec_t v, input string tag);
    logic [5:0] exp_deb;
    logic [1:0] exp_code;
    logic       exp_chg;
    set_raw(v.raw);
    for (int e = 1; e <= D + 3; e++) begin
      step();
      exp_deb  = (e >= D + 2) ? v.deb : prev_deb;
      exp_code = (e >= D + 3) ? v.code : prev_code;
      exp_chg  = (e == D + 2) && (v.deb != prev_deb);
      check($sformatf("%s deb e%0d", tag, e), deb_out(), {2'b00, exp_deb});
      check($sformatf("%s changed e%0d", tag, e), {7'd0, bus.changed}, {7'd0, exp_chg});
      check($sformatf("%s code e%0d", tag, e), {6'd0, bus.level_code}, {6'd0, exp_code});
    end
    check({tag, " err"}, {7'd0, bus.level_err}, 8'd0);
    prev_deb  = v.deb;
    prev_code = v.code;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{6'b000111, 6'b000111, 2'd3};
    vecs[1] = '{6'b000011, 6'b000011, 2'd2};
    vecs[2] = '{6'b000001, 6'b000001, 2'd1};
    vecs[3] = '{6'b000000, 6'b000000, 2'd0};
    vecs[4] = '{6'b101001, 6'b101001, 2'd1};
    vecs[5] = '{6'b010011, 6'b010011, 2'd2};
    vecs[6] = '{6'b000111, 6'b000111, 2'd3};

    // Reset state
    reset = 1'b0;
    bus.err_clr = 1'b0;
    set_raw(6'b000000);
    step();
    step();
    check("reset deb", deb_out(), 8'd0);
    check("reset code", {6'd0, bus.level_code}, 8'd0);
    check("reset changed", {7'd0, bus.changed}, 8'd0);
    check("reset err", {7'd0, bus.level_err}, 8'd0);
    prev_deb  = 6'b000000;
    prev_code = 2'd0;
    reset = 1'b1;

    // Table of valid patterns; first entry is the full-tank-after-reset case.
    for (int i = 0; i < 7; i++) begin
      apply_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Short ua pulse: 10 cycles high must be rejected.
    set_raw(6'b001111);
    for (int e = 1; e <= 30; e++) begin
      if (e == 11) set_raw(6'b000111);
      step();
      check($sformatf("glitch ua e%0d", e), {7'd0, bus.ua}, 8'd0);
      check($sformatf("glitch changed e%0d", e), {7'd0, bus.changed}, 8'd0);
    end

    // Implausible pattern 101 from full tank.
    set_raw(6'b000101);
    for (int e = 1; e <= D + 1; e++) step();
    check("imp pre deb", deb_out(), 8'b00000111);
    step();
    check("imp deb 101", deb_out(), 8'b00000101);
    check("imp changed", {7'd0, bus.changed}, 8'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("imp err k%0d", k), {7'd0, bus.level_err}, 8'd0);
      check($sformatf("imp code k%0d", k), {6'd0, bus.level_code}, 8'd3);
    end
    step();
    check("imp err set", {7'd0, bus.level_err}, {7'd0, PL});
    check("imp code held", {6'd0, bus.level_code}, 8'd3);
    bus.err_clr = 1'b1;
    step();
    step();
    bus.err_clr = 1'b0;
    check("imp clr ignored", {7'd0, bus.level_err}, {7'd0, PL});
    check("imp code held2", {6'd0, bus.level_code}, 8'd3);

    // Back to 011 (hh and mm flip on the same edge); flag stays until cleared.
    set_raw(6'b000011);
    for (int e = 1; e <= D + 1; e++) step();
    check("ret pre deb", deb_out(), 8'b00000101);
    step();
    check("ret deb 011", deb_out(), 8'b00000011);
    check("ret changed", {7'd0, bus.changed}, 8'd1);
    check("ret err kept", {7'd0, bus.level_err}, {7'd0, PL});
    step();
    check("ret code", {6'd0, bus.level_code}, 8'd2);
    check("ret err kept2", {7'd0, bus.level_err}, {7'd0, PL});
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("clr err", {7'd0, bus.level_err}, 8'd0);
    check("clr code", {6'd0, bus.level_code}, 8'd2);
    step();
    check("clr err stays", {7'd0, bus.level_err}, 8'd0);

    // Reset in the middle of t and us debounce counts.
    set_raw(6'b100011);
    for (int e = 1; e <= 12; e++) step();
    set_raw(6'b110011);
    step();
    step();
    reset = 1'b0;
    step();
    step();
    check("mid rst deb", deb_out(), 8'd0);
    check("mid rst code", {6'd0, bus.level_code}, 8'd0);
    check("mid rst changed", {7'd0, bus.changed}, 8'd0);
    check("mid rst err", {7'd0, bus.level_err}, 8'd0);
    reset = 1'b1;
    prev_deb  = 6'b000000;
    prev_code = 2'd0;
    apply_vec('{6'b110011, 6'b110011, 2'd2}, "post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive mismatching cycles required to accept a new input level (range 2..255).
REQ-002 SHALL have parameter ERR_HOLD, default 4, consecutive implausible-level cycles required to raise level_err (range 1..15).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports hh_raw, mm_raw, ll_raw  input  1 each  raw tank level probes (high, medium, low).
REQ-006 SHALL have ports ua_raw, us_raw, t_raw  input  1 each  raw air-humidity, soil-humidity and temperature switches.
REQ-007 SHALL have port err_clr  input  1  request to clear sticky level_err.
REQ-008 SHALL have ports hh, mm, ll, ua, us, t  output  1 each  debounced sensor values feeding the level and irrigation logic.
REQ-009 SHALL have port level_code  output  2  0 empty, 1 low, 2 medium, 3 full.
REQ-010 SHALL have port changed  output  1  single-cycle pulse on any debounced output update.
REQ-011 SHALL have port level_err  output  1  sticky probe-plausibility error.

Function
REQ-012 Each raw input SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Each channel SHALL have an 8-bit counter: cleared when synchronized value equals its debounced output; incremented while they differ.
REQ-014 When counter = DEBOUNCE_CYCLES-1 and values still differ, that edge SHALL load the debounced output with the synchronized value and clear the counter.
REQ-015 Latency: counting the first edge sampling a new stable raw level as edge 1, the debounced output SHALL change at edge DEBOUNCE_CYCLES+2 (edge 18 at default).
REQ-016 A raw pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave the output unchanged and leave the counter at 0 once the pulse ends.
REQ-017 Channels SHALL be independent; simultaneous updates on several channels SHALL all occur on the same edge.
REQ-018 changed SHALL be registered, high for exactly one cycle in the cycle following any edge where at least one debounced output changed; it SHALL not stretch when updates occur on consecutive edges (one pulse per update edge).
REQ-019 Valid debounced patterns {hh,mm,ll}: 000->0, 001->1, 011->2, 111->3; level_code SHALL register the mapped value one cycle after the pattern appears.
REQ-020 On any other pattern level_code SHALL hold its last valid value and a 4-bit implausibility counter SHALL increment, saturating at ERR_HOLD.
REQ-021 level_err SHALL set on the edge the implausibility counter reaches ERR_HOLD; a valid pattern SHALL clear the counter but not level_err.
REQ-022 err_clr high with a valid pattern SHALL clear level_err on that edge; with an invalid pattern level_err SHALL remain set (set wins).

Reset
REQ-023 With reset low at a rising edge, all synchronizers, counters, debounced outputs, level_code, changed and level_err SHALL be 0, regardless of in-progress counts.
REQ-024 After reset release, inputs already at 1 SHALL propagate only after full DEBOUNCE_CYCLES+2 latency, producing a changed pulse.

Configuration
REQ-025 Macro SENSOR_PLAUSIBILITY_EN defined: REQ-020 to REQ-022 implemented as stated.
REQ-026 Macro SENSOR_PLAUSIBILITY_EN undefined: implausibility counter and level_err logic omitted, level_err tied 0, err_clr ignored; invalid patterns still hold level_code.

Verification
REQ-027 Reset low 2 cycles, release, hh/mm/ll_raw=1 -> ll,mm,hh =1 at edge 18, changed pulse 1 cycle, level_code=3 at edge 19.
REQ-028 ua_raw high for 10 cycles then low, DEBOUNCE_CYCLES=16 -> ua stays 0, no changed pulse.
REQ-029 Debounced {hh,mm,ll}=101 held 4 cycles -> level_err=1 on 4th cycle, level_code holds prior value; err_clr during 101 -> level_err stays 1.
REQ-030 Return to 011 then err_clr 1 cycle -> level_err=0 next cycle, level_code=2.
REQ-031 us_raw toggled high at count 10 of t_raw debounce, reset low at count 12 -> all outputs 0, no pending update after release.
REQ-032 Build without SENSOR_PLAUSIBILITY_EN, repeat REQ-029 -> level_err=0 throughout, level_code held.
